// File: rtl/npu_result_reader_if.sv
// Valid/ready element stream carrying NPU results to the downstream consumer.
interface npu_result_reader_if #(
    parameter int unsigned ACC_W = 17,
    parameter int unsigned IDX_W = 2
);
    logic             valid;
    logic             ready;
    logic [ACC_W-1:0] data;
    logic [IDX_W-1:0] index;
    logic             last;

    modport master (
        output valid,
        output data,
        output index,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        input  index,
        input  last,
        output ready
    );
endinterface

// File: rtl/npu_result_reader.sv
// Snapshots the NPU accumulator array on a pdone rising edge and streams the
// elements out row-major, one per valid/ready transfer.
module npu_result_reader #(
    parameter int unsigned N     = 2,
    parameter int unsigned ACC_W = 16 + (N - 1),
    parameter int unsigned IDX_W = (N * N > 1) ? $clog2(N * N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ACC_W-1:0]     npu_out [N*N],
    input  logic                 pdone,
    npu_result_reader_if.master  m,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 clear_overrun,
    output logic [7:0]           frame_cnt
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N * N - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pdone_q;
    logic [ACC_W-1:0] snap_q [N*N];
    logic [ACC_W-1:0] snap_d [N*N];
    logic             overrun_q, overrun_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d;

    logic cap;
    logic xfer;
    logic at_last;

    assign cap     = pdone & ~pdone_q;
    assign at_last = (idx_q == LAST_IDX);

    assign m.valid   = (state_q == STREAM);
    assign m.data    = snap_q[idx_q];
    assign m.index   = idx_q;
    assign m.last    = m.valid & at_last;
    assign busy      = m.valid;
    assign overrun   = overrun_q;
    assign frame_cnt = frame_cnt_q;
    assign xfer      = m.valid & m.ready;

    // State, index, snapshot and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pdone_q     <= 1'b0;
            snap_q      <= '{default: '0};
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pdone_q     <= pdone;
            snap_q      <= snap_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Next-state logic: capture, advance on transfer, recapture on the last
    // transfer, and flag completion edges that arrive mid-frame.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_d      = snap_q;
        frame_cnt_d = frame_cnt_q;
        overrun_d   = overrun_q;

        if (clear_overrun) begin
            overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (cap) begin
                    snap_d  = npu_out;
                    idx_d   = '0;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (xfer && at_last) begin
                    frame_cnt_d = frame_cnt_q + 8'd1;
                    idx_d       = '0;
                    if (cap) begin
                        snap_d = npu_out;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (xfer) begin
                        idx_d = idx_q + 1'b1;
                    end
                    // Set wins over a same-cycle clear.
                    if (cap) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_npu_result_reader.sv
// Directed testbench for npu_result_reader with N=2.
module tb_npu_result_reader;

    localparam int unsigned N     = 2;
    localparam int unsigned ACC_W = 17;
    localparam int unsigned IDX_W = 2;

    logic             clk;
    logic             rst;
    logic [ACC_W-1:0] npu_out [N*N];
    logic             pdone;
    logic             busy;
    logic             overrun;
    logic             clear_overrun;
    logic [7:0]       frame_cnt;

    int tests_run;
    int tests_failed;

    npu_result_reader_if #(.ACC_W(ACC_W), .IDX_W(IDX_W)) m_if ();

    npu_result_reader #(.N(N), .ACC_W(ACC_W), .IDX_W(IDX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .npu_out       (npu_out),
        .pdone         (pdone),
        .m             (m_if),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun),
        .frame_cnt     (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ACC_W-1:0] frame_a [N*N];
    logic [ACC_W-1:0] frame_b [N*N];
    logic [ACC_W-1:0] frame_7 [N*N];

    task automatic do_reset;
        rst           = 1'b1;
        pdone         = 1'b0;
        m_if.ready    = 1'b0;
        clear_overrun = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++;
        if (m_if.valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b exp 0", m_if.valid); end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
        tests_run++;
        if (m_if.last !== 1'b0) begin tests_failed++; $display("FAIL reset_last got %b exp 0", m_if.last); end
        tests_run++;
        if (m_if.index !== 2'd0) begin tests_failed++; $display("FAIL reset_index got %0d exp 0", m_if.index); end
        tests_run++;
        if (m_if.data !== 17'd0) begin tests_failed++; $display("FAIL reset_data got %0d exp 0", m_if.data); end
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        tests_run++;
        if (frame_cnt !== 8'd0) begin tests_failed++; $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); end
    endtask

    task automatic test_basic_frame;
        do_reset();
        npu_out    = frame_a;
        pdone      = 1'b1;
        m_if.ready = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            tests_run++;
            if (m_if.valid !== 1'b1 || busy !== 1'b1) begin tests_failed++; $display("FAIL basic_valid[%0d] got v=%b b=%b exp 1", e, m_if.valid, busy); end
            tests_run++;
            if (m_if.data !== frame_a[e]) begin tests_failed++; $display("FAIL basic_data[%0d] got %0d exp %0d", e, m_if.data, frame_a[e]); end
            tests_run++;
            if (m_if.index !== e[1:0]) begin tests_failed++; $display("FAIL basic_index[%0d] got %0d exp %0d", e, m_if.index, e); end
            tests_run++;
            if (m_if.last !== (e == 3)) begin tests_failed++; $display("FAIL basic_last[%0d] got %b exp %b", e, m_if.last, (e == 3)); end
        end
        @(negedge clk);
        tests_run++;
        if (m_if.valid !== 1'b0 || busy !== 1'b0) begin tests_failed++; $display("FAIL basic_done_valid got v=%b b=%b exp 0", m_if.valid, busy); end
        tests_run++;
        if (frame_cnt !== 8'd1) begin tests_failed++; $display("FAIL basic_frame_cnt got %0d exp 1", frame_cnt); end
        pdone = 1'b0;
    endtask

    task automatic test_backpressure;
        logic pat [7];
        int   e;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        do_reset();
        npu_out    = frame_a;
        pdone      = 1'b1;
        m_if.ready = 1'b0;
        e          = 0;
        for (int s = 0; s < 7; s++) begin
            @(negedge clk);
            npu_out = frame_7;
            tests_run++;
            if (m_if.valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid[%0d] got %b exp 1", s, m_if.valid); end
            tests_run++;
            if (m_if.data !== frame_a[e]) begin tests_failed++; $display("FAIL bp_data[%0d] got %0d exp %0d", s, m_if.data, frame_a[e]); end
            tests_run++;
            if (m_if.index !== e[1:0]) begin tests_failed++; $display("FAIL bp_index[%0d] got %0d exp %0d", s, m_if.index, e); end
            tests_run++;
            if (m_if.last !== (e == 3)) begin tests_failed++; $display("FAIL bp_last[%0d] got %b exp %b", s, m_if.last, (e == 3)); end
            m_if.ready = pat[s];
            if (pat[s]) e++;
        end
        @(negedge clk);
        tests_run++;
        if (m_if.valid !== 1'b0) begin tests_failed++; $display("FAIL bp_done_valid got %b exp 0", m_if.valid); end
        tests_run++;
        if (frame_cnt !== 8'd1) begin tests_failed++; $display("FAIL bp_frame_cnt got %0d exp 1", frame_cnt); end
        pdone = 1'b0;
    endtask

    task automatic test_overrun;
        do_reset();
        npu_out    = frame_a;
        pdone      = 1'b1;
        m_if.ready = 1'b1;
        @(negedge clk);                 // element 0
        pdone = 1'b0;
        @(negedge clk);                 // element 1, pdone_q now 0
        tests_run++;
        if (m_if.index !== 2'd1) begin tests_failed++; $display("FAIL ovr_pre_index got %0d exp 1", m_if.index); end
        npu_out    = frame_b;
        pdone      = 1'b1;
        m_if.ready = 1'b0;
        @(negedge clk);
        tests_run++;
        if (overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_set got %b exp 1", overrun); end
        tests_run++;
        if (m_if.index !== 2'd1 || m_if.data !== 17'd22) begin tests_failed++; $display("FAIL ovr_hold got idx=%0d data=%0d exp idx=1 data=22", m_if.index, m_if.data); end
        m_if.ready = 1'b1;
        for (int e = 1; e < 4; e++) begin
            if (e > 1) @(negedge clk);
            tests_run++;
            if (m_if.valid !== 1'b1 || m_if.data !== frame_a[e]) begin tests_failed++; $display("FAIL ovr_data[%0d] got v=%b data=%0d exp v=1 data=%0d", e, m_if.valid, m_if.data, frame_a[e]); end
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            tests_run++;
            if (m_if.valid !== 1'b0) begin tests_failed++; $display("FAIL ovr_no_second[%0d] got valid %b exp 0", c, m_if.valid); end
        end
        tests_run++;
        if (frame_cnt !== 8'd1 || overrun !== 1'b1) begin tests_failed++; $display("FAIL ovr_after got cnt=%0d ovr=%b exp cnt=1 ovr=1", frame_cnt, overrun); end
        clear_overrun = 1'b1;
        @(negedge clk);
        clear_overrun = 1'b0;
        tests_run++;
        if (overrun !== 1'b0) begin tests_failed++; $display("FAIL ovr_clear got %b exp 0", overrun); end
        pdone = 1'b0;
    endtask

    task automatic test_back_to_back;
        do_reset();
        npu_out    = frame_a;
        pdone      = 1'b1;
        m_if.ready = 1'b1;
        @(negedge clk);                 // element 0
        @(negedge clk);                 // element 1
        pdone = 1'b0;
        @(negedge clk);                 // element 2
        @(negedge clk);                 // element 3
        tests_run++;
        if (m_if.data !== 17'd50 || m_if.last !== 1'b1) begin tests_failed++; $display("FAIL b2b_last1 got data=%0d last=%b exp 50/1", m_if.data, m_if.last); end
        npu_out = frame_b;
        pdone   = 1'b1;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            tests_run++;
            if (m_if.valid !== 1'b1 || m_if.data !== frame_b[e] || m_if.index !== e[1:0]) begin
                tests_failed++;
                $display("FAIL b2b_elem[%0d] got v=%b data=%0d idx=%0d exp v=1 data=%0d idx=%0d", e, m_if.valid, m_if.data, m_if.index, frame_b[e], e);
            end
            if (e == 0) begin
                tests_run++;
                if (overrun !== 1'b0 || frame_cnt !== 8'd1) begin tests_failed++; $display("FAIL b2b_status got ovr=%b cnt=%0d exp 0/1", overrun, frame_cnt); end
            end
        end
        @(negedge clk);
        tests_run++;
        if (m_if.valid !== 1'b0 || frame_cnt !== 8'd2) begin tests_failed++; $display("FAIL b2b_done got v=%b cnt=%0d exp 0/2", m_if.valid, frame_cnt); end
        pdone = 1'b0;
    endtask

    task automatic test_level_hold;
        int valid_cycles;
        do_reset();
        npu_out      = frame_a;
        pdone        = 1'b1;
        m_if.ready   = 1'b1;
        valid_cycles = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_if.valid === 1'b1) valid_cycles++;
        end
        tests_run++;
        if (valid_cycles != 4) begin tests_failed++; $display("FAIL level_valid_cycles got %0d exp 4", valid_cycles); end
        tests_run++;
        if (frame_cnt !== 8'd1) begin tests_failed++; $display("FAIL level_frame_cnt got %0d exp 1", frame_cnt); end
        pdone = 1'b0;
    endtask

    task automatic test_reset_mid_frame;
        do_reset();
        npu_out    = frame_a;
        pdone      = 1'b1;
        m_if.ready = 1'b1;
        repeat (5) @(negedge clk);      // first frame streamed, now idle
        pdone = 1'b0;
        @(negedge clk);
        pdone = 1'b1;
        @(negedge clk);                 // second frame, element 0
        pdone = 1'b0;
        @(negedge clk);                 // element 1
        pdone = 1'b1;                   // mid-frame edge -> overrun
        @(negedge clk);                 // element 2
        tests_run++;
        if (m_if.index !== 2'd2 || overrun !== 1'b1 || frame_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL rstmid_pre got idx=%0d ovr=%b cnt=%0d exp 2/1/1", m_if.index, overrun, frame_cnt);
        end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (m_if.valid !== 1'b0 || busy !== 1'b0 || m_if.index !== 2'd0 || frame_cnt !== 8'd0 || overrun !== 1'b0) begin
            tests_failed++;
            $display("FAIL rstmid_async got v=%b b=%b idx=%0d cnt=%0d ovr=%b exp all 0", m_if.valid, busy, m_if.index, frame_cnt, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            tests_run++;
            if (m_if.valid !== 1'b1 || m_if.data !== frame_a[e] || m_if.index !== e[1:0]) begin
                tests_failed++;
                $display("FAIL rstmid_new[%0d] got v=%b data=%0d idx=%0d exp v=1 data=%0d idx=%0d", e, m_if.valid, m_if.data, m_if.index, frame_a[e], e);
            end
        end
        @(negedge clk);
        tests_run++;
        if (m_if.valid !== 1'b0 || frame_cnt !== 8'd1) begin tests_failed++; $display("FAIL rstmid_done got v=%b cnt=%0d exp 0/1", m_if.valid, frame_cnt); end
        pdone = 1'b0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        frame_a       = '{17'd19, 17'd22, 17'd43, 17'd50};
        frame_b       = '{17'd1, 17'd2, 17'd3, 17'd4};
        frame_7       = '{17'd7, 17'd7, 17'd7, 17'd7};
        npu_out       = '{default: '0};
        rst           = 1'b1;
        pdone         = 1'b0;
        clear_overrun = 1'b0;
        m_if.ready    = 1'b0;

        test_reset();
        test_basic_frame();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_level_hold();
        test_reset_mid_frame();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/npu_result_reader.md
# npu_result_reader

Result-drain block for the systolic matrix-multiply NPU. It snapshots the NPU's N×N accumulator output array when the NPU signals completion, then streams the elements out one per transfer, row-major, over a valid/ready interface. It sits between `simpleNPU` (`out`, `PDONE`) and the downstream result consumer (bus writer or host FIFO), so the NPU never has to hold its outputs stable while the consumer drains them.

## Interface
- `N`, default 2: matrix dimension; the frame is N*N elements.
- `ACC_W`, default 16+(N-1): element width; must match the NPU output width.
- `IDX_W`, default max(1, $clog2(N*N)): element index width.

- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `npu_out` in ACC_W × [N*N]: unpacked NPU result array. Element i is row i/N, column i%N.
- `pdone` in 1: NPU completion level; a capture is triggered by its rising edge.
- `m_valid` out 1: output element valid.
- `m_ready` in 1: consumer accepts the element.
- `m_data` out ACC_W: current element.
- `m_index` out IDX_W: index 0..N*N-1 of `m_data`.
- `m_last` out 1: high with the element at index N*N-1.
- `busy` out 1: high while a frame is being streamed (state STREAM).
- `overrun` out 1: sticky; a completion edge arrived while busy.
- `clear_overrun` in 1: synchronous clear of `overrun`.
- `frame_cnt` out 8: completed-frame counter, wraps 255→0.

## Operation
- Edge detect: `pdone_q` is registered each cycle; `cap = pdone & ~pdone_q`. `pdone_q` resets to 0, so `pdone` already high when reset is released counts as an edge on the first clock.
- Transfer: `xfer = m_valid & m_ready`.
- The FSM has two states, IDLE and STREAM.
- IDLE:
  - On `cap`: load all N*N `npu_out` elements into the snapshot registers, set idx=0, and go to STREAM.
  - Without `cap`: stay in IDLE.
- STREAM:
  - `m_valid`=1, `m_data`=snap[idx], `m_index`=idx, `m_last`=(idx==N*N-1).
  - On `xfer` with idx below the last element: idx+1.
  - On `xfer` at the last element: `frame_cnt`+1.
    - If `cap` is also high that cycle: recapture, idx=0, stay in STREAM. No bubble, no overrun.
    - Otherwise: go to IDLE.
  - `cap` in any other STREAM cycle: ignored for capture. `overrun` is set and the current frame continues unchanged.
- Hold rule: while `m_valid` is high and `m_ready` is low, `m_data`, `m_index` and `m_last` stay stable. The snapshot is never modified mid-frame, whatever `npu_out` does.
- `overrun`:
  - Set has priority over `clear_overrun` in the same cycle.
  - Cleared only by `clear_overrun` or `rst`.
- Reset (async, usable at any time including mid-frame):
  - State IDLE, idx 0, `pdone_q` 0.
  - `m_valid`, `m_last`, `busy`, `overrun` are 0; `m_index` is 0; `frame_cnt` is 0.
  - Snapshot registers and `m_data` reset to 0.
  - A partial frame is discarded and not counted.
- Width: elements are passed unmodified at ACC_W bits, with no truncation or sign handling.

## Timing
- Capture latency: a `pdone` rising edge sampled at edge k gives `m_valid`=1 with element 0 in the cycle after edge k.
- Throughput: one element per cycle when `m_ready` is held high, so a frame takes N*N cycles (4 for N=2).
- After the last transfer (without recapture), `m_valid` is 0 in the next cycle.
- `busy` equals `m_valid`; both are registered state, not combinational on `m_ready`.
- `frame_cnt` updates in the cycle after the last transfer.
- `overrun` is visible in the cycle after the offending edge.
- `m_valid` does not depend combinationally on `m_ready`.

## Test plan
- **Basic 2×2 frame**
  - Stimulus: N=2; `npu_out`={19,22,43,50} (A=[[1,2],[3,4]], B=[[5,6],[7,8]]); `pdone` 0→1; `m_ready`=1.
  - Response: one cycle after the edge, the stream is 19,22,43,50 on 4 consecutive cycles with `m_index` 0..3 and `m_last` only on 50. Then `m_valid`=0 and `frame_cnt`=1.
- **Backpressure**
  - Stimulus: same frame, `m_ready` toggled 1,0,0,1,0,1,1; `npu_out` changed to all 7 after capture.
  - Response: data is still 19,22,43,50, held stable across every stall, and all 7s never appear.
- **Overrun**
  - Stimulus: `pdone` falls and rises again while idx=1.
  - Response: `overrun`=1 the next cycle; the current frame completes unchanged; no second frame starts.
  - Follow-up: `clear_overrun` pulse → `overrun`=0.
- **Back-to-back frames**
  - Stimulus: the `pdone` edge coincides with the last transfer of frame 1; new `npu_out`={1,2,3,4}.
  - Response: the cycle right after 50 presents 1 with `m_index`=0; `overrun`=0; `frame_cnt` reaches 2 after the second frame.
- **Level hold**
  - Stimulus: `pdone` held high across two full frame durations.
  - Response: exactly one frame is streamed.
- **Reset mid-frame**
  - Stimulus: assert `rst` asynchronously at idx=2.
  - Response: `m_valid`, `busy`, `m_index`, `frame_cnt` and `overrun` go to 0 immediately.
  - Follow-up: after release with `pdone`=1, one new frame starts from index 0.
